// File: rtl/gnss_pkg.sv
// Shared types and defaults for the GNSS correlator blocks.
package gnss_pkg;

    localparam int SAMPLE_W_DEFAULT = 4;
    localparam int ACC_W_DEFAULT    = 20;

    typedef enum logic {
        IDLE  = 1'b0,
        INTEG = 1'b1
    } corr_state_t;

    // Symmetric-except-for-one saturation limits of a default-width accumulator.
    localparam logic [ACC_W_DEFAULT-1:0] ACC_MAX = {1'b0, {(ACC_W_DEFAULT-1){1'b1}}};
    localparam logic [ACC_W_DEFAULT-1:0] ACC_MIN = {1'b1, {(ACC_W_DEFAULT-1){1'b0}}};

    function automatic logic [3:0] eff_epochs(input logic [3:0] n);
        return (n == 4'd0) ? 4'd1 : n;
    endfunction

endpackage

// File: rtl/sat_acc.sv
// Single-channel saturating signed accumulator with clear, load and add.
module sat_acc #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic         add,
    input  logic [W-1:0] din,
    output logic [W-1:0] acc,
    output logic         ovf
);

    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    logic [W:0] sum;
    logic       sat;

    // One guard bit: overflow shows up as disagreement between the top two bits.
    assign sum = {acc[W-1], acc} + {din[W-1], din};
    assign sat = sum[W] ^ sum[W-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clear) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (load) begin
            acc <= din;
            ovf <= 1'b0;
        end else if (add) begin
            if (sat) begin
                acc <= sum[W] ? SAT_MIN : SAT_MAX;
                ovf <= 1'b1;
            end else begin
                acc <= sum[W-1:0];
            end
        end
    end

endmodule

// File: rtl/cacode_corr_dump.sv
// C/A code wipe-off and accumulate-and-dump correlator producing one I/Q dump
// per programmable number of code periods.
module cacode_corr_dump
    import gnss_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
    parameter int ACC_W    = ACC_W_DEFAULT,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_reg,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic [SAMPLE_W-1:0] sample_q,
    input  logic                chip,
    input  logic                epoch,
    input  logic [3:0]          n_epochs,
    output logic [ACC_W-1:0]    acc_i,
    output logic [ACC_W-1:0]    acc_q,
    output logic [CNT_W-1:0]    dump_cnt,
    output logic                dump_ovf,
    output logic                dump_valid,
    output logic                armed
);

    corr_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       epoch_cnt_reg, epoch_cnt_next;
    logic [3:0]       n_eff_reg, n_eff_next;
    logic             acc_clear, acc_load, acc_add, dump;

    logic [SAMPLE_W-1:0] samp   [2];
    logic [ACC_W-1:0]    acc_sum[2];
    logic [1:0]          ovf_ch;

    assign samp[0] = sample_i;
    assign samp[1] = sample_q;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic [SAMPLE_W:0] ext;
            logic [SAMPLE_W:0] prod;
            logic [ACC_W-1:0]  prod_ext;

            // Widen before negating so the most negative sample flips without wrap.
            assign ext      = {samp[gi][SAMPLE_W-1], samp[gi]};
            assign prod     = chip ? ext : -ext;
            assign prod_ext = {{(ACC_W-SAMPLE_W-1){prod[SAMPLE_W]}}, prod};

            sat_acc #(.W(ACC_W)) u_acc (
                .clk   (clk),
                .rst   (rst),
                .clear (acc_clear),
                .load  (acc_load),
                .add   (acc_add),
                .din   (prod_ext),
                .acc   (acc_sum[gi]),
                .ovf   (ovf_ch[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        epoch_cnt_next = epoch_cnt_reg;
        n_eff_next     = n_eff_reg;
        acc_clear      = 1'b0;
        acc_load       = 1'b0;
        acc_add        = 1'b0;
        dump           = 1'b0;

        if (set_reg) begin
            state_next     = IDLE;
            cnt_next       = '0;
            epoch_cnt_next = '0;
            acc_clear      = 1'b1;
        end else if (sample_valid) begin
            case (state_reg)
                IDLE: begin
                    if (epoch) begin
                        state_next     = INTEG;
                        acc_load       = 1'b1;
                        cnt_next       = {{(CNT_W-1){1'b0}}, 1'b1};
                        epoch_cnt_next = 4'd1;
                        n_eff_next     = eff_epochs(n_epochs);
                    end
                end
                INTEG: begin
                    if (epoch && (epoch_cnt_reg == n_eff_reg)) begin
                        dump           = 1'b1;
                        acc_load       = 1'b1;
                        cnt_next       = {{(CNT_W-1){1'b0}}, 1'b1};
                        epoch_cnt_next = 4'd1;
                        n_eff_next     = eff_epochs(n_epochs);
                    end else begin
                        acc_add  = 1'b1;
                        cnt_next = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;
                        if (epoch) begin
                            epoch_cnt_next = epoch_cnt_reg + 4'd1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            epoch_cnt_reg <= '0;
            n_eff_reg     <= '0;
            acc_i         <= '0;
            acc_q         <= '0;
            dump_cnt      <= '0;
            dump_ovf      <= 1'b0;
            dump_valid    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            epoch_cnt_reg <= epoch_cnt_next;
            n_eff_reg     <= n_eff_next;
            dump_valid    <= dump;
            // Dump captures the sums before the epoch sample is folded in.
            if (dump) begin
                acc_i    <= acc_sum[0];
                acc_q    <= acc_sum[1];
                dump_cnt <= cnt_reg;
                dump_ovf <= |ovf_ch;
            end
        end
    end

    assign armed = (state_reg == INTEG);

endmodule

// File: tb/tb_cacode_corr_dump.sv
// Directed bench for cacode_corr_dump: table of full intervals plus hand sequences.
module tb_cacode_corr_dump;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        set_reg = 1'b0;
    logic        sample_valid = 1'b0;
    logic [3:0]  sample_i = '0;
    logic [3:0]  sample_q = '0;
    logic        chip = 1'b1;
    logic        epoch = 1'b0;
    logic [3:0]  n_epochs = 4'd1;

    logic [19:0] acc_i, acc_q;
    logic [15:0] dump_cnt;
    logic        dump_ovf, dump_valid, armed;
    logic [7:0]  acc_i8, acc_q8;
    logic [15:0] dump_cnt8;
    logic        dump_ovf8, dump_valid8, armed8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cacode_corr_dump dut (
        .clk(clk), .rst(rst), .set_reg(set_reg), .sample_valid(sample_valid),
        .sample_i(sample_i), .sample_q(sample_q), .chip(chip), .epoch(epoch),
        .n_epochs(n_epochs), .acc_i(acc_i), .acc_q(acc_q), .dump_cnt(dump_cnt),
        .dump_ovf(dump_ovf), .dump_valid(dump_valid), .armed(armed)
    );

    cacode_corr_dump #(.ACC_W(8)) dut8 (
        .clk(clk), .rst(rst), .set_reg(set_reg), .sample_valid(sample_valid),
        .sample_i(sample_i), .sample_q(sample_q), .chip(chip), .epoch(epoch),
        .n_epochs(n_epochs), .acc_i(acc_i8), .acc_q(acc_q8), .dump_cnt(dump_cnt8),
        .dump_ovf(dump_ovf8), .dump_valid(dump_valid8), .armed(armed8)
    );

    typedef struct {
        int n;      // n_epochs applied
        int si;
        int sq;
        int mode;   // 0: chip=1, 1: chip=0, 2: alternating starting at 1
        int period;
        int ei;
        int eq;
        int ecnt;
        int eovf;
    } vec_t;

    vec_t vecs[5];
    int   seen;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One valid sample; seen counts dump pulses observed right after it.
    task automatic send(input int si, input int sq, input logic c, input logic e);
        logic [31:0] vi, vq;
        vi = si;
        vq = sq;
        sample_valid = 1'b1;
        sample_i = vi[3:0];
        sample_q = vq[3:0];
        chip = c;
        epoch = e;
        step();
        sample_valid = 1'b0;
        epoch = 1'b0;
        if (dump_valid) seen++;
    endtask

    task automatic restart();
        set_reg = 1'b1;
        step();
        set_reg = 1'b0;
    endtask

    function automatic logic chip_of(input int mode, input int j);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'b0;
        return (j % 2) == 0;
    endfunction

    initial begin
        vecs[0] = '{n:1, si:3,  sq:-2, mode:0, period:1023, ei:3069, eq:-2046, ecnt:1023, eovf:0};
        vecs[1] = '{n:2, si:-8, sq:1,  mode:2, period:10,   ei:0,    eq:0,     ecnt:20,   eovf:0};
        vecs[2] = '{n:2, si:-8, sq:5,  mode:1, period:10,   ei:160,  eq:-100,  ecnt:20,   eovf:0};
        vecs[3] = '{n:0, si:-3, sq:7,  mode:0, period:7,    ei:-21,  eq:49,    ecnt:7,    eovf:0};
        vecs[4] = '{n:3, si:2,  sq:-1, mode:1, period:5,    ei:-30,  eq:15,    ecnt:15,   eovf:0};

        // Reset state
        repeat (3) step();
        chk("reset_acc_i", int'($signed(acc_i)), 0);
        chk("reset_dump_cnt", int'(dump_cnt), 0);
        chk("reset_armed", int'(armed), 0);
        chk("reset_dump_valid", int'(dump_valid), 0);
        rst = 1'b1;
        step();

        // Samples without an epoch never arm
        seen = 0;
        for (int k = 0; k < 5; k++) send(5, -3, 1'b1, 1'b0);
        chk("idle_armed", int'(armed), 0);
        chk("idle_no_dump", seen, 0);
        chk("idle_acc_i", int'($signed(acc_i)), 0);
        chk("idle_acc_q", int'($signed(acc_q)), 0);
        $display("txn idle: armed=%0d dumps=%0d", armed, seen);

        // Table of complete intervals
        for (int v = 0; v < 5; v++) begin
            int neff, j;
            restart();
            n_epochs = 4'(vecs[v].n);
            neff = (vecs[v].n == 0) ? 1 : vecs[v].n;
            seen = 0;
            j = 0;
            for (int p = 0; p < neff; p++) begin
                for (int k = 0; k < vecs[v].period; k++) begin
                    send(vecs[v].si, vecs[v].sq, chip_of(vecs[v].mode, j), k == 0);
                    j++;
                end
            end
            chk($sformatf("v%0d_early_dump", v), seen, 0);
            send(vecs[v].si, vecs[v].sq, chip_of(vecs[v].mode, j), 1'b1);
            chk($sformatf("v%0d_dump_valid", v), int'(dump_valid), 1);
            chk($sformatf("v%0d_acc_i", v), int'($signed(acc_i)), vecs[v].ei);
            chk($sformatf("v%0d_acc_q", v), int'($signed(acc_q)), vecs[v].eq);
            chk($sformatf("v%0d_dump_cnt", v), int'(dump_cnt), vecs[v].ecnt);
            chk($sformatf("v%0d_dump_ovf", v), int'(dump_ovf), vecs[v].eovf);
            $display("txn vec%0d: acc_i=%0d acc_q=%0d cnt=%0d ovf=%0d", v,
                     $signed(acc_i), $signed(acc_q), dump_cnt, dump_ovf);
            step();
            chk($sformatf("v%0d_pulse_one_cycle", v), int'(dump_valid), 0);
        end

        // Saturation in the 8-bit build, then a clean interval clears ovf
        restart();
        n_epochs = 4'd1;
        for (int k = 0; k < 50; k++) send(7, 0, 1'b1, k == 0);
        send(0, 0, 1'b1, 1'b1);
        chk("sat8_dump_valid", int'(dump_valid8), 1);
        chk("sat8_acc_i", int'($signed(acc_i8)), 127);
        chk("sat8_ovf", int'(dump_ovf8), 1);
        chk("sat8_cnt", int'(dump_cnt8), 50);
        chk("sat20_acc_i", int'($signed(acc_i)), 350);
        chk("sat20_ovf", int'(dump_ovf), 0);
        $display("txn sat: acc_i8=%0d ovf8=%0d acc_i=%0d", $signed(acc_i8), dump_ovf8, $signed(acc_i));
        for (int k = 0; k < 49; k++) send(0, 0, 1'b1, 1'b0);
        send(0, 0, 1'b1, 1'b1);
        chk("sat8_clear_acc_i", int'($signed(acc_i8)), 0);
        chk("sat8_clear_ovf", int'(dump_ovf8), 0);
        $display("txn sat_clear: acc_i8=%0d ovf8=%0d", $signed(acc_i8), dump_ovf8);
        step();

        // set_reg beats a simultaneous epoch sample
        restart();
        n_epochs = 4'd1;
        for (int k = 0; k < 4; k++) send(1, 0, 1'b1, k == 0);
        send(1, 0, 1'b1, 1'b1);
        chk("setreg_pre_acc_i", int'($signed(acc_i)), 4);
        for (int k = 0; k < 3; k++) send(1, 0, 1'b1, 1'b0);
        set_reg = 1'b1;
        send(1, 0, 1'b1, 1'b1);
        set_reg = 1'b0;
        chk("setreg_armed", int'(armed), 0);
        chk("setreg_no_dump", int'(dump_valid), 0);
        chk("setreg_hold_acc_i", int'($signed(acc_i)), 4);
        seen = 0;
        for (int k = 0; k < 3; k++) send(1, 0, 1'b1, 1'b0);
        chk("setreg_stay_idle", int'(armed), 0);
        send(2, 0, 1'b1, 1'b1);
        chk("setreg_rearm", int'(armed), 1);
        for (int k = 0; k < 3; k++) send(2, 0, 1'b1, 1'b0);
        chk("setreg_no_dump_after", seen, 0);
        send(2, 0, 1'b1, 1'b1);
        chk("setreg_new_acc_i", int'($signed(acc_i)), 8);
        chk("setreg_new_cnt", int'(dump_cnt), 4);
        $display("txn set_reg: acc_i=%0d cnt=%0d", $signed(acc_i), dump_cnt);
        step();

        // n_epochs change takes effect only at the next dump
        restart();
        n_epochs = 4'd1;
        send(1, 0, 1'b1, 1'b1);
        n_epochs = 4'd3;
        for (int k = 0; k < 3; k++) send(1, 0, 1'b1, 1'b0);
        send(1, 0, 1'b1, 1'b1);
        chk("nchg_first_dump", int'(dump_valid), 1);
        chk("nchg_first_cnt", int'(dump_cnt), 4);
        seen = 0;
        for (int k = 1; k < 12; k++) send(1, 0, 1'b1, (k % 4) == 0);
        chk("nchg_no_mid_dump", seen, 0);
        send(1, 0, 1'b1, 1'b1);
        chk("nchg_second_dump", int'(dump_valid), 1);
        chk("nchg_second_cnt", int'(dump_cnt), 12);
        chk("nchg_second_acc_i", int'($signed(acc_i)), 12);
        $display("txn n_change: cnt=%0d acc_i=%0d", dump_cnt, $signed(acc_i));
        step();

        // Back-to-back epochs with n_eff=1 give consecutive dumps
        restart();
        n_epochs = 4'd1;
        send(5, 0, 1'b1, 1'b1);
        send(-4, 0, 1'b1, 1'b1);
        chk("b2b_first_valid", int'(dump_valid), 1);
        chk("b2b_first_acc_i", int'($signed(acc_i)), 5);
        send(1, 0, 1'b1, 1'b1);
        chk("b2b_second_valid", int'(dump_valid), 1);
        chk("b2b_second_acc_i", int'($signed(acc_i)), -4);
        chk("b2b_second_cnt", int'(dump_cnt), 1);
        $display("txn b2b: acc_i=%0d cnt=%0d", $signed(acc_i), dump_cnt);
        step();

        // Reset mid-integration loses the partial sum without a dump
        for (int k = 0; k < 3; k++) send(3, 0, 1'b1, 1'b0);
        rst = 1'b0;
        step();
        chk("rst_mid_dump_valid", int'(dump_valid), 0);
        chk("rst_mid_acc_i", int'($signed(acc_i)), 0);
        chk("rst_mid_armed", int'(armed), 0);
        rst = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cacode_corr_dump.md
Name: cacode_corr_dump

Overview:
- Accumulate-and-dump correlator, directly downstream of the C/A code generator.
- Wipes the code off the incoming baseband I/Q samples using the generator's `chip` output, then integrates over a programmable number of code periods.
- Presents one coherent I/Q dump per integration interval to the tracking-loop logic.
- Code periods are delimited by an `epoch` strobe that is aligned to the first sample of each code period.

Parameters:
- SAMPLE_W, 4, signed I/Q sample width.
- ACC_W, 20, signed accumulator and dump width.
- CNT_W, 16, width of the per-dump sample counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-low reset.
- set_reg  in  1  synchronous restart, issued together with code generator reload.
- sample_valid  in  1  sample strobe for sample_i/sample_q/chip/epoch.
- sample_i  in  SAMPLE_W  signed in-phase sample.
- sample_q  in  SAMPLE_W  signed quadrature sample.
- chip  in  1  current code chip; 1 = +1, 0 = -1.
- epoch  in  1  high with the sample that is the first of a code period.
- n_epochs  in  4  code periods per dump; 0 is treated as 1.
- acc_i  out  ACC_W  last dumped I sum.
- acc_q  out  ACC_W  last dumped Q sum.
- dump_cnt  out  CNT_W  samples contained in the last dump.
- dump_ovf  out  1  saturation occurred during the last dump.
- dump_valid  out  1  one-cycle pulse when acc_i/acc_q/dump_cnt/dump_ovf update.
- armed  out  1  high while integrating.

Behaviour:
- Reset: active when `rst`=0 at a clk edge. All outputs go to 0 and the state goes to IDLE.
- States:
  - IDLE: waiting for the first epoch.
  - INTEG: integrating.
- IDLE -> INTEG: on a cycle with sample_valid & epoch.
  - The accumulators load that sample's product.
  - The sample counter loads 1; the epoch counter loads 1.
  - n_eff = max(n_epochs, 1) is latched.
  - Samples without epoch while in IDLE are discarded.
- Product:
  - Sign-extend the sample to SAMPLE_W+1 bits before negating, so -8 becomes +8 without wrap.
  - chip=1 gives +sample; chip=0 gives -sample.
  - Sign-extend to ACC_W before adding.
- INTEG, sample_valid without epoch:
  - acc += product, saturating at ±(2^(ACC_W-1)-1) / -2^(ACC_W-1).
  - Sticky ovf is set if saturation occurred.
  - Sample counter increments, saturating at all-ones.
- INTEG, sample_valid with epoch while epoch counter < n_eff: same as above, and the epoch counter increments.
- INTEG, sample_valid with epoch while epoch counter == n_eff: dump.
  - acc_i/acc_q/dump_cnt/dump_ovf take the accumulated values excluding the current sample.
  - dump_valid=1 on the next cycle (1-cycle latency from the epoch sample edge).
  - The accumulators restart with the current product; counters restart at 1.
  - ovf clears; n_eff is re-latched from n_epochs.
- Timing of n_epochs: a change of n_epochs mid-interval takes effect at the next dump only.
- sample_valid=0: no state change. chip/epoch/sample inputs are ignored.
- set_reg=1:
  - Goes to IDLE and clears the accumulators and counters.
  - Has priority over a simultaneous sample, which is discarded.
  - Dump outputs hold their values; dump_valid=0.
- rst mid-integration: the partial sum is lost and no dump is issued.
- Outputs are held between dumps.
- dump_valid is never high on consecutive cycles unless epochs arrive on consecutive valid samples with n_eff=1.

Decomposition:
- Shared package gnss_pkg:
  - SAMPLE_W, ACC_W defaults.
  - Typedef `corr_state_t` {IDLE, INTEG}.
  - Saturation limits as localparams derived from ACC_W.
- One natural sub-module, `sat_acc`: a single-channel saturating signed accumulator with clear/load/add and ovf output, instantiated twice (I and Q).

Test Plan:
1. Reset release, then 5 valid samples with epoch=0 -> armed=0, no dump_valid, all outputs 0.
2. n_epochs=1, sample_i=+3, sample_q=-2, chip=1, 1023 samples per period, epochs every 1023 -> dump_valid 1 cycle after the 2nd epoch; acc_i=3069, acc_q=-2046, dump_cnt=1023, dump_ovf=0.
3. chip alternating 1/0, sample_i=-8, n_epochs=2, period 10 -> acc_i=0, dump_cnt=20; with chip constant 0 -> acc_i=+160 (no wrap of -(-8)).
4. ACC_W=8 build, sample_i=+7, chip=1, period 50 -> acc_i=127, dump_ovf=1; the next dump with sample_i=0 -> acc_i=0, dump_ovf=0.
5. set_reg asserted mid-interval with a simultaneous valid epoch sample -> armed=0, no dump, previous acc_i held; re-arms on the next epoch.
6. n_epochs changed 1->3 mid-interval -> the current dump still after 1 epoch; the following dump after 3 epochs; n_epochs=0 behaves as 1.
